// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259A-style read/write control stage.
// Holds the init-sequence state encoding and read-source codes.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ICW2,
    ST_WAIT_ICW3,
    ST_WAIT_ICW4,
    ST_READY
  } rwc_state_t;

  localparam logic [1:0] READ_SRC_IRR = 2'd0;
  localparam logic [1:0] READ_SRC_ISR = 2'd1;
  localparam logic [1:0] READ_SRC_IMR = 2'd2;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int OCW_D3    = 3;
  localparam int OCW_D4    = 4;
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;

endpackage

// File: rtl/rwc_strobe_sync.sv
// Input stage for CS_n/RD_n/WR_n/A0: one register, or a 2-flop
// synchronizer when RWC_SYNC_EN is defined (adds 1 clk of latency).
module rwc_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_cs_n,
  input  logic i_rd_n,
  input  logic i_wr_n,
  input  logic i_a0,
  output logic o_cs_n,
  output logic o_rd_n,
  output logic o_wr_n,
  output logic o_a0
);

  localparam logic [3:0] IDLE_V = 4'b1110;

  logic [3:0] r_sync;

`ifdef RWC_SYNC_EN
  logic [3:0] r_meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= IDLE_V;
      r_sync <= IDLE_V;
    end else begin
      r_meta <= {i_cs_n, i_rd_n, i_wr_n, i_a0};
      r_sync <= r_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= IDLE_V;
    end else begin
      r_sync <= {i_cs_n, i_rd_n, i_wr_n, i_a0};
    end
  end
`endif

  assign {o_cs_n, o_rd_n, o_wr_n, o_a0} = r_sync;

endmodule

// File: rtl/rw_control_logic.sv
// 8259A-style read/write control: strobe qualification, ICW/OCW decode,
// init-sequence FSM. Optional RWC_SYNC_EN adds an input synchronizer.
module rw_control_logic
  import pic_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CS_n,
  input  logic              RD_n,
  input  logic              WR_n,
  input  logic              A0,
  input  logic [DATA_W-1:0] Ds_to_W_R,
  output logic              RD_flag,
  output logic              WR_flag,
  output logic              icw1_wr,
  output logic              icw2_wr,
  output logic              icw3_wr,
  output logic              icw4_wr,
  output logic              ocw1_wr,
  output logic              ocw2_wr,
  output logic              ocw3_wr,
  output logic [DATA_W-1:0] cmd_data,
  output logic              init_done,
  output logic              sngl,
  output logic              ic4,
  output logic [1:0]        read_src
);

  logic w_cs_n;
  logic w_rd_n;
  logic w_wr_n;
  logic w_a0;

  rwc_strobe_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_cs_n (CS_n),
    .i_rd_n (RD_n),
    .i_wr_n (WR_n),
    .i_a0   (A0),
    .o_cs_n (w_cs_n),
    .o_rd_n (w_rd_n),
    .o_wr_n (w_wr_n),
    .o_a0   (w_a0)
  );

  rwc_state_t        r_state;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wa0;
  logic [1:0]        r_rd_sel;

  logic w_wr_act;
  logic w_rd_act;
  logic w_commit;
  logic w_is_icw1;
  logic w_is_ocw2;
  logic w_is_ocw3;
  logic w_is_port1;

  assign w_wr_act = ~w_cs_n & ~w_wr_n;
  assign w_rd_act = ~w_cs_n & ~w_rd_n & ~w_wr_act;
  // falling edge of the registered write flag closes the cycle
  assign w_commit = WR_flag & ~w_wr_act;

  assign w_is_icw1  = ~r_wa0 & r_wdata[OCW_D4];
  assign w_is_ocw2  = ~r_wa0 & ~r_wdata[OCW_D4] & ~r_wdata[OCW_D3];
  assign w_is_ocw3  = ~r_wa0 & ~r_wdata[OCW_D4] & r_wdata[OCW_D3];
  assign w_is_port1 = r_wa0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_wdata   <= '0;
      r_wa0     <= 1'b0;
      r_rd_sel  <= READ_SRC_IRR;
      RD_flag   <= 1'b0;
      WR_flag   <= 1'b0;
      icw1_wr   <= 1'b0;
      icw2_wr   <= 1'b0;
      icw3_wr   <= 1'b0;
      icw4_wr   <= 1'b0;
      ocw1_wr   <= 1'b0;
      ocw2_wr   <= 1'b0;
      ocw3_wr   <= 1'b0;
      cmd_data  <= '0;
      init_done <= 1'b0;
      sngl      <= 1'b0;
      ic4       <= 1'b0;
      read_src  <= READ_SRC_IRR;
    end else begin
      WR_flag <= w_wr_act;
      RD_flag <= w_rd_act;
      icw1_wr <= 1'b0;
      icw2_wr <= 1'b0;
      icw3_wr <= 1'b0;
      icw4_wr <= 1'b0;
      ocw1_wr <= 1'b0;
      ocw2_wr <= 1'b0;
      ocw3_wr <= 1'b0;

      if (w_wr_act) begin
        r_wdata <= Ds_to_W_R;
        r_wa0   <= w_a0;
      end

      if (w_rd_act) begin
        read_src <= w_a0 ? READ_SRC_IMR : r_rd_sel;
      end

      if (w_commit) begin
        unique case (1'b1)
          w_is_icw1: begin
            icw1_wr   <= 1'b1;
            cmd_data  <= r_wdata;
            sngl      <= r_wdata[ICW1_SNGL];
            ic4       <= r_wdata[ICW1_IC4];
            init_done <= 1'b0;
            r_rd_sel  <= READ_SRC_IRR;
            r_state   <= ST_WAIT_ICW2;
          end
          w_is_ocw2: begin
            if (r_state == ST_READY) begin
              ocw2_wr  <= 1'b1;
              cmd_data <= r_wdata;
            end
          end
          w_is_ocw3: begin
            if (r_state == ST_READY) begin
              ocw3_wr  <= 1'b1;
              cmd_data <= r_wdata;
              if (r_wdata[OCW3_RR]) begin
                r_rd_sel <= r_wdata[OCW3_RIS] ? READ_SRC_ISR
                                              : READ_SRC_IRR;
              end
            end
          end
          w_is_port1: begin
            case (r_state)
              ST_WAIT_ICW2: begin
                icw2_wr  <= 1'b1;
                cmd_data <= r_wdata;
                if (!sngl) begin
                  r_state <= ST_WAIT_ICW3;
                end else if (ic4) begin
                  r_state <= ST_WAIT_ICW4;
                end else begin
                  r_state   <= ST_READY;
                  init_done <= 1'b1;
                end
              end
              ST_WAIT_ICW3: begin
                icw3_wr  <= 1'b1;
                cmd_data <= r_wdata;
                if (ic4) begin
                  r_state <= ST_WAIT_ICW4;
                end else begin
                  r_state   <= ST_READY;
                  init_done <= 1'b1;
                end
              end
              ST_WAIT_ICW4: begin
                icw4_wr   <= 1'b1;
                cmd_data  <= r_wdata;
                r_state   <= ST_READY;
                init_done <= 1'b1;
              end
              ST_READY: begin
                ocw1_wr  <= 1'b1;
                cmd_data <= r_wdata;
              end
              default: ;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rw_control_logic.sv
// Self-checking bench for rw_control_logic: directed scenarios plus
// randomized traffic against a queue-based model of the init sequence.
module tb_rw_control_logic;

`ifdef RWC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam logic [6:0] S_ICW1 = 7'b0000001;
  localparam logic [6:0] S_OCW1 = 7'b0010000;
  localparam logic [6:0] S_OCW2 = 7'b0100000;
  localparam logic [6:0] S_OCW3 = 7'b1000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       CS_n = 1'b1;
  logic       RD_n = 1'b1;
  logic       WR_n = 1'b1;
  logic       A0 = 1'b0;
  logic [7:0] Ds_to_W_R = 8'h00;
  logic       RD_flag, WR_flag;
  logic       icw1_wr, icw2_wr, icw3_wr, icw4_wr;
  logic       ocw1_wr, ocw2_wr, ocw3_wr;
  logic [7:0] cmd_data;
  logic       init_done, sngl, ic4;
  logic [1:0] read_src;
  logic [6:0] w_stb;

  int checks = 0;
  int errors = 0;

  // model: pending ICW numbers still owed after ICW1
  int         m_q[$];
  bit         m_init;
  bit         m_isr;
  bit         m_sngl;
  bit         m_ic4;
  logic [7:0] m_cmd;

  rw_control_logic dut (
    .clk       (clk),
    .reset     (reset),
    .CS_n      (CS_n),
    .RD_n      (RD_n),
    .WR_n      (WR_n),
    .A0        (A0),
    .Ds_to_W_R (Ds_to_W_R),
    .RD_flag   (RD_flag),
    .WR_flag   (WR_flag),
    .icw1_wr   (icw1_wr),
    .icw2_wr   (icw2_wr),
    .icw3_wr   (icw3_wr),
    .icw4_wr   (icw4_wr),
    .ocw1_wr   (ocw1_wr),
    .ocw2_wr   (ocw2_wr),
    .ocw3_wr   (ocw3_wr),
    .cmd_data  (cmd_data),
    .init_done (init_done),
    .sngl      (sngl),
    .ic4       (ic4),
    .read_src  (read_src)
  );

  assign w_stb = {ocw3_wr, ocw2_wr, ocw1_wr,
                  icw4_wr, icw3_wr, icw2_wr, icw1_wr};

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_init = 0;
    m_isr  = 0;
    m_sngl = 0;
    m_ic4  = 0;
    m_cmd  = 8'h00;
  endtask

  task automatic model_commit(input bit a0, input logic [7:0] d,
                              output logic [6:0] exp);
    int n;
    exp = 7'b0;
    if (!a0 && d[4]) begin
      exp = S_ICW1;
      m_sngl = d[1];
      m_ic4  = d[0];
      m_q.delete();
      m_q.push_back(2);
      if (!d[1]) m_q.push_back(3);
      if (d[0]) m_q.push_back(4);
      m_init = 0;
      m_isr  = 0;
      m_cmd  = d;
    end else if (!a0) begin
      if (m_init) begin
        exp = d[3] ? S_OCW3 : S_OCW2;
        if (d[3] && d[1]) m_isr = d[0];
        m_cmd = d;
      end
    end else if (m_q.size() > 0) begin
      n = m_q.pop_front();
      exp = 7'(1 << (n - 1));
      m_cmd = d;
      if (m_q.size() == 0) m_init = 1;
    end else if (m_init) begin
      exp = S_OCW1;
      m_cmd = d;
    end
  endtask

  task automatic do_write(input bit a0, input logic [7:0] d,
                          input bit rd_too);
    logic [6:0] exp;
    logic [6:0] req;
    @(negedge clk);
    CS_n = 0;
    WR_n = 0;
    RD_n = rd_too ? 1'b0 : 1'b1;
    A0 = a0;
    Ds_to_W_R = d;
    repeat (3) @(negedge clk);
    checks++;
    if (WR_flag !== 1'b1 || RD_flag !== 1'b0) begin
      errors++;
      $display("FAIL wr_flags: WR_flag=%b RD_flag=%b required 1 0",
               WR_flag, RD_flag);
    end
    model_commit(a0, d, exp);
    WR_n = 1;
    CS_n = 1;
    RD_n = 1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      req = (k == LAT) ? exp : 7'b0;
      checks++;
      if (w_stb !== req) begin
        errors++;
        $display("FAIL strobe a0=%b d=%h cyc=%0d: got %b required %b",
                 a0, d, k, w_stb, req);
      end
    end
    checks++;
    if (cmd_data !== m_cmd || init_done !== m_init ||
        sngl !== m_sngl || ic4 !== m_ic4) begin
      errors++;
      $display("FAIL state a0=%b d=%h: cmd=%h init=%b sngl=%b ic4=%b required %h %b %b %b",
               a0, d, cmd_data, init_done, sngl, ic4,
               m_cmd, m_init, m_sngl, m_ic4);
    end
  endtask

  task automatic do_read(input bit a0);
    logic [1:0] req;
    req = a0 ? 2'd2 : (m_isr ? 2'd1 : 2'd0);
    @(negedge clk);
    CS_n = 0;
    RD_n = 0;
    A0 = a0;
    repeat (3) @(negedge clk);
    checks++;
    if (RD_flag !== 1'b1 || WR_flag !== 1'b0 || read_src !== req) begin
      errors++;
      $display("FAIL read a0=%b: RD=%b WR=%b src=%0d required 1 0 %0d",
               a0, RD_flag, WR_flag, read_src, req);
    end
    CS_n = 1;
    RD_n = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (w_stb !== 7'b0 || read_src !== req || RD_flag !== 1'b0) begin
      errors++;
      $display("FAIL read_tail: stb=%b src=%0d RD=%b required 0 %0d 0",
               w_stb, read_src, RD_flag, req);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({RD_flag, WR_flag, w_stb, cmd_data, init_done,
         sngl, ic4, read_src} !== '0) begin
      errors++;
      $display("FAIL reset_state: stb=%b cmd=%h init=%b src=%0d required all 0",
               w_stb, cmd_data, init_done, read_src);
    end
    reset = 0;
    model_reset();
  endtask

  task automatic test_init_single();
    do_write(0, 8'h13, 0);
    do_write(1, 8'h20, 0);
    do_write(1, 8'h01, 0);
  endtask

  task automatic test_init_cascade();
    do_write(0, 8'h11, 0);
    do_write(1, 8'h20, 0);
    do_write(1, 8'h04, 0);
    do_write(1, 8'h01, 0);
    do_write(1, 8'hFF, 0);
  endtask

  task automatic test_ocw3_read();
    do_write(0, 8'h0B, 0);
    do_read(0);
    do_read(1);
    do_write(0, 8'h0A, 0);
    do_read(0);
    do_write(0, 8'h20, 0);
  endtask

  task automatic test_strobe_qual();
    do_write(1, 8'h5A, 1);
    @(negedge clk);
    CS_n = 1;
    WR_n = 0;
    A0 = 1;
    Ds_to_W_R = 8'hC3;
    repeat (3) @(negedge clk);
    checks++;
    if (WR_flag !== 1'b0 || RD_flag !== 1'b0) begin
      errors++;
      $display("FAIL no_cs_flags: WR=%b RD=%b required 0 0",
               WR_flag, RD_flag);
    end
    WR_n = 1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      checks++;
      if (w_stb !== 7'b0 || cmd_data !== m_cmd) begin
        errors++;
        $display("FAIL no_cs_strobe: stb=%b cmd=%h required 0 %h",
                 w_stb, cmd_data, m_cmd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e1, e2;
    logic [7:0] exp_cmd[$];
    int pulses;
    pulses = 0;
    model_commit(1, 8'h3C, e1);
    exp_cmd.push_back(m_cmd);
    model_commit(1, 8'hA5, e2);
    exp_cmd.push_back(m_cmd);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        CS_n = 0; WR_n = 0; A0 = 1; Ds_to_W_R = 8'h3C;
      end
      if (i == 2) begin
        CS_n = 1; WR_n = 1;
      end
      if (i == 3) begin
        CS_n = 0; WR_n = 0;
      end
      if (i == 3 + LAT - 2) Ds_to_W_R = 8'hA5;
      if (i == 5) begin
        CS_n = 1; WR_n = 1;
      end
      if (w_stb !== 7'b0) begin
        pulses++;
        checks++;
        if (w_stb !== S_OCW1 || exp_cmd.size() == 0 ||
            cmd_data !== exp_cmd[0]) begin
          errors++;
          $display("FAIL b2b_pulse: stb=%b cmd=%h required %b %h",
                   w_stb, cmd_data, S_OCW1,
                   exp_cmd.size() > 0 ? exp_cmd[0] : 8'h00);
        end
        if (exp_cmd.size() > 0) void'(exp_cmd.pop_front());
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d required 2", pulses);
    end
  endtask

  task automatic test_icw1_restart();
    do_write(0, 8'h11, 0);
    do_write(1, 8'h20, 0);
    do_write(0, 8'h13, 0);
    do_write(1, 8'h28, 0);
    do_write(1, 8'h01, 0);
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    CS_n = 0;
    WR_n = 0;
    A0 = 0;
    Ds_to_W_R = 8'h17;
    repeat (3) @(negedge clk);
    reset = 1;
    CS_n = 1;
    WR_n = 1;
    @(negedge clk);
    checks++;
    if ({RD_flag, WR_flag, w_stb, cmd_data, init_done,
         sngl, ic4, read_src} !== '0) begin
      errors++;
      $display("FAIL reset_mid: stb=%b cmd=%h init=%b sngl=%b ic4=%b required all 0",
               w_stb, cmd_data, init_done, sngl, ic4);
    end
    reset = 0;
    model_reset();
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      checks++;
      if (w_stb !== 7'b0) begin
        errors++;
        $display("FAIL reset_no_strobe: stb=%b required 0", w_stb);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] d;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      if (r < 2) begin
        do_write(0, d | 8'h10, 0);
      end else if (r < 5) begin
        do_write(1, d, 0);
      end else if (r < 7) begin
        do_write(0, d & 8'hEF, 0);
      end else begin
        do_read(r[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_single();
    test_init_cascade();
    test_ocw3_read();
    test_strobe_qual();
    test_back_to_back();
    test_icw1_restart();
    test_reset_mid_write();
    test_init_single();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
